// File: rtl/mmc_cmd_defs.sv
// Shared definitions for the SPI-mode MMC/SD command issuer: FSM states,
// response-type codes and error codes.
package mmc_cmd_defs;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_RESP_REQ,
    ST_RESP_GET,
    ST_EXT_REQ,
    ST_EXT_GET,
    ST_BSY_REQ,
    ST_BSY_GET,
    ST_END
  } cmdState_t;

  localparam logic [1:0] RESP_R1   = 2'd0;
  localparam logic [1:0] RESP_R1B  = 2'd1;
  localparam logic [1:0] RESP_R3R7 = 2'd2;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_R1_TIMEOUT   = 2'b01;
  localparam logic [1:0] ERR_BUSY_TIMEOUT = 2'b10;

  localparam logic [7:0] IDLE_BYTE  = 8'hFF;
  localparam logic [2:0] FRAME_LEN  = 3'd6;

endpackage

// File: rtl/mmc_crc7_byte.sv
// Byte-wide CRC7 (x^7 + x^3 + 1, init 0) accumulator for the command frame.
module mmc_crc7_byte (
  input  logic       iCLOCK,
  input  logic       iRESET,
  input  logic       iCLEAR,
  input  logic       iUPDATE,
  input  logic [7:0] iDATA,
  output logic [6:0] oCRC
);

  logic [6:0] crcReg;
  logic [6:0] crcNext;

  function automatic logic [6:0] nextCrc(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always_comb crcNext = nextCrc(crcReg, iDATA);

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET)       crcReg <= '0;
    else if (iCLEAR)  crcReg <= '0;
    else if (iUPDATE) crcReg <= crcNext;
  end

  assign oCRC = crcReg;

endmodule

// File: rtl/mmc_cmd_control_layer_generic.sv
// Generic SPI-mode MMC/SD command issuer: frames CMD+arg+CRC7, polls R1,
// then optionally collects a 4-byte R3/R7 payload or waits out R1b busy.
//
// state    | meaning
// IDLE     | waiting for start, CS high
// CMD      | sending the 6-byte command frame
// RESP_REQ | requesting an R1 poll byte
// RESP_GET | waiting for the R1 poll byte
// EXT_REQ  | requesting an R3/R7 payload byte
// EXT_GET  | waiting for the payload byte
// BSY_REQ  | requesting an R1b busy poll byte
// BSY_GET  | waiting for the busy poll byte
// END      | one-cycle completion pulse, CS high
module mmc_cmd_control_layer_generic
  import mmc_cmd_defs::*;
#(
  parameter int unsigned P_RESP_TIMEOUT = 8,
  parameter int unsigned P_BUSY_TIMEOUT = 16'hFFFF,
  parameter int unsigned P_CRC_EN       = 1
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iRESET_SYNC,
  input  logic        iCMD_START,
  input  logic [5:0]  iCMD_INDEX,
  input  logic [31:0] iCMD_ARG,
  input  logic [1:0]  iCMD_RESP_TYPE,
  output logic        oCMD_BUSY,
  output logic        oCMD_END,
  output logic [1:0]  oCMD_ERROR,
  output logic [7:0]  oCMD_R1,
  output logic [31:0] oCMD_RESP_DATA,
  output logic        oMMC_REQ,
  input  logic        iMMC_BUSY,
  output logic        oMMC_CS,
  output logic [7:0]  oMMC_DATA,
  input  logic        iMMC_VALID,
  input  logic [7:0]  iMMC_DATA
);

  localparam logic [7:0]  RESP_TO = 8'(P_RESP_TIMEOUT);
  localparam logic [15:0] BUSY_TO = 16'(P_BUSY_TIMEOUT);

  cmdState_t   state, stateNext;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArg;
  logic [1:0]  respType;
  logic [2:0]  byteCnt;
  logic [7:0]  pollCnt;
  logic [15:0] busyCnt;
  logic [1:0]  extCnt;
  logic [1:0]  errorReg;
  logic [7:0]  r1Reg;
  logic [31:0] respData;
  logic [6:0]  crc;
  logic [7:0]  frameByte;
  logic        startNow;

  assign startNow = (state == ST_IDLE) && iCMD_START;

  mmc_crc7_byte uCrc (
    .iCLOCK (iCLOCK),
    .iRESET (iRESET),
    .iCLEAR (iRESET_SYNC || startNow),
    .iUPDATE(state == ST_CMD && oMMC_REQ && byteCnt < 3'd5),
    .iDATA  (frameByte),
    .oCRC   (crc)
  );

  always_comb begin
    frameByte = IDLE_BYTE;
    case (byteCnt)
      3'd0: frameByte = {2'b01, cmdIndex};
      3'd1: frameByte = cmdArg[31:24];
      3'd2: frameByte = cmdArg[23:16];
      3'd3: frameByte = cmdArg[15:8];
      3'd4: frameByte = cmdArg[7:0];
      3'd5: frameByte = (P_CRC_EN != 0) ? {crc, 1'b1} : IDLE_BYTE;
      default: frameByte = IDLE_BYTE;
    endcase
  end

  always_comb begin
    stateNext = state;
    oMMC_REQ  = 1'b0;
    case (state)
      ST_IDLE:     if (iCMD_START) stateNext = ST_CMD;
      ST_CMD:      if (byteCnt == FRAME_LEN) stateNext = ST_RESP_REQ;
                   else oMMC_REQ = !iMMC_BUSY;
      ST_RESP_REQ: begin
        oMMC_REQ = !iMMC_BUSY;
        if (!iMMC_BUSY) stateNext = ST_RESP_GET;
      end
      ST_RESP_GET: if (iMMC_VALID) begin
        if (!iMMC_DATA[7]) begin
          if (respType == RESP_R3R7)     stateNext = ST_EXT_REQ;
          else if (respType == RESP_R1B) stateNext = ST_BSY_REQ;
          else                           stateNext = ST_END;
        end else begin
          stateNext = (pollCnt == RESP_TO) ? ST_END : ST_RESP_REQ;
        end
      end
      ST_EXT_REQ: begin
        oMMC_REQ = !iMMC_BUSY;
        if (!iMMC_BUSY) stateNext = ST_EXT_GET;
      end
      ST_EXT_GET:  if (iMMC_VALID) stateNext = (extCnt == 2'd3) ? ST_END : ST_EXT_REQ;
      ST_BSY_REQ: begin
        oMMC_REQ = !iMMC_BUSY;
        if (!iMMC_BUSY) stateNext = ST_BSY_GET;
      end
      ST_BSY_GET:  if (iMMC_VALID) begin
        if (iMMC_DATA == IDLE_BYTE || busyCnt == BUSY_TO) stateNext = ST_END;
        else                                              stateNext = ST_BSY_REQ;
      end
      ST_END:      stateNext = ST_IDLE;
      default:     stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state <= ST_IDLE;  cmdIndex <= '0;  cmdArg <= '0;   respType <= '0;
      byteCnt <= '0;     pollCnt <= '0;   busyCnt <= '0;  extCnt <= '0;
      errorReg <= ERR_NONE;  r1Reg <= IDLE_BYTE;  respData <= '0;
    end else if (iRESET_SYNC) begin
      state <= ST_IDLE;  cmdIndex <= '0;  cmdArg <= '0;   respType <= '0;
      byteCnt <= '0;     pollCnt <= '0;   busyCnt <= '0;  extCnt <= '0;
      errorReg <= ERR_NONE;  r1Reg <= IDLE_BYTE;  respData <= '0;
    end else begin
      state <= stateNext;
      case (state)
        ST_IDLE: if (iCMD_START) begin
          cmdIndex <= iCMD_INDEX;  cmdArg <= iCMD_ARG;  respType <= iCMD_RESP_TYPE;
          byteCnt <= '0;  pollCnt <= '0;  busyCnt <= '0;  extCnt <= '0;
          errorReg <= ERR_NONE;  r1Reg <= IDLE_BYTE;  respData <= '0;
        end
        ST_CMD:      if (oMMC_REQ) byteCnt <= byteCnt + 3'd1;
        ST_RESP_REQ: if (oMMC_REQ) pollCnt <= pollCnt + 8'd1;
        ST_RESP_GET: if (iMMC_VALID) begin
          if (!iMMC_DATA[7])           r1Reg    <= iMMC_DATA;
          else if (pollCnt == RESP_TO) errorReg <= ERR_R1_TIMEOUT;
        end
        ST_EXT_GET:  if (iMMC_VALID) begin
          respData <= {respData[23:0], iMMC_DATA};
          extCnt   <= extCnt + 2'd1;
        end
        ST_BSY_REQ:  if (oMMC_REQ) busyCnt <= busyCnt + 16'd1;
        ST_BSY_GET:  if (iMMC_VALID && iMMC_DATA != IDLE_BYTE && busyCnt == BUSY_TO)
                       errorReg <= ERR_BUSY_TIMEOUT;
        default: ;
      endcase
    end
  end

  assign oCMD_BUSY      = (state != ST_IDLE);
  assign oCMD_END       = (state == ST_END);
  assign oCMD_ERROR     = errorReg;
  assign oCMD_R1        = r1Reg;
  assign oCMD_RESP_DATA = respData;
  assign oMMC_CS        = (state == ST_IDLE) || (state == ST_END);
  assign oMMC_DATA      = (state == ST_CMD) ? frameByte : IDLE_BYTE;

endmodule

// File: tb/tb_mmc_cmd_control_layer_generic.sv
// Directed bench for the MMC command issuer with a simple byte-level SPI master model.
module tb_mmc_cmd_control_layer_generic;

  logic        iCLOCK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iRESET_SYNC = 1'b0;
  logic        iCMD_START = 1'b0;
  logic [5:0]  iCMD_INDEX = '0;
  logic [31:0] iCMD_ARG = '0;
  logic [1:0]  iCMD_RESP_TYPE = '0;
  logic        iMMC_BUSY = 1'b0;
  logic        iMMC_VALID = 1'b0;
  logic [7:0]  iMMC_DATA = 8'hFF;

  logic        cBusy, cEnd, cReq, cCs;
  logic [1:0]  cErr;
  logic [7:0]  cR1, cMmcData;
  logic [31:0] cData;
  logic        bBusy, bEnd, bReq, bCs;
  logic [1:0]  bErr;
  logic [7:0]  bR1, bMmcData;
  logic [31:0] bData;

  int vectors = 0;
  int miscompares = 0;
  int endCnt0 = 0;
  int endCnt1 = 0;
  int e0, e1;

  logic [7:0] txLog[$];
  logic [7:0] rxQ[$];
  logic       pendV = 1'b0;
  logic [7:0] pendD = 8'hFF;

  mmc_cmd_control_layer_generic #(.P_RESP_TIMEOUT(8), .P_BUSY_TIMEOUT(16'hFFFF), .P_CRC_EN(1)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
    .iCMD_START(iCMD_START), .iCMD_INDEX(iCMD_INDEX), .iCMD_ARG(iCMD_ARG),
    .iCMD_RESP_TYPE(iCMD_RESP_TYPE), .oCMD_BUSY(cBusy), .oCMD_END(cEnd),
    .oCMD_ERROR(cErr), .oCMD_R1(cR1), .oCMD_RESP_DATA(cData),
    .oMMC_REQ(cReq), .iMMC_BUSY(iMMC_BUSY), .oMMC_CS(cCs), .oMMC_DATA(cMmcData),
    .iMMC_VALID(iMMC_VALID), .iMMC_DATA(iMMC_DATA)
  );

  mmc_cmd_control_layer_generic #(.P_RESP_TIMEOUT(8), .P_BUSY_TIMEOUT(2), .P_CRC_EN(1)) dutShortBusy (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iRESET_SYNC(iRESET_SYNC),
    .iCMD_START(iCMD_START), .iCMD_INDEX(iCMD_INDEX), .iCMD_ARG(iCMD_ARG),
    .iCMD_RESP_TYPE(iCMD_RESP_TYPE), .oCMD_BUSY(bBusy), .oCMD_END(bEnd),
    .oCMD_ERROR(bErr), .oCMD_R1(bR1), .oCMD_RESP_DATA(bData),
    .oMMC_REQ(bReq), .iMMC_BUSY(iMMC_BUSY), .oMMC_CS(bCs), .oMMC_DATA(bMmcData),
    .iMMC_VALID(iMMC_VALID), .iMMC_DATA(iMMC_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  // SPI master model: a byte accepted at a posedge returns its rx byte one cycle later.
  // The first six bytes of a command are the frame and return FF.
  always @(negedge iCLOCK) begin
    logic [7:0] d;
    iMMC_VALID = pendV;
    iMMC_DATA  = pendD;
    pendV = 1'b0;
    if (cReq) begin
      if (txLog.size() >= 6 && rxQ.size() > 0) d = rxQ.pop_front();
      else d = 8'hFF;
      txLog.push_back(cMmcData);
      pendV = 1'b1;
      pendD = d;
    end
  end

  always @(negedge iCLOCK) begin
    if (cEnd) endCnt0++;
    if (bEnd) endCnt1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic startCmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype);
    tick();
    txLog.delete();
    iCMD_START = 1'b1;
    iCMD_INDEX = idx;
    iCMD_ARG = arg;
    iCMD_RESP_TYPE = rtype;
    tick();
    iCMD_START = 1'b0;
  endtask

  task automatic waitEnd(input string tag, input int budget);
    int n;
    n = 0;
    while (!cEnd && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_end_seen"}, 32'(cEnd), 32'd1);
  endtask

  task automatic waitTx(input string tag, input int count, input int budget);
    int n;
    n = 0;
    while (txLog.size() < count && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_tx_reached"}, 32'(txLog.size() >= count), 32'd1);
  endtask

  function automatic logic [7:0] txAt(input int i);
    if (i < txLog.size()) return txLog[i];
    return 8'hXX;
  endfunction

  function automatic logic [7:0] crcByte5(input logic [39:0] f);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ f[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  initial begin
    repeat (3) tick();
    iRESET = 1'b0;
    tick();
    check("rst_busy", 32'(cBusy), 32'd0);
    check("rst_end",  32'(cEnd),  32'd0);
    check("rst_err",  32'(cErr),  32'd0);
    check("rst_r1",   32'(cR1),   32'hFF);
    check("rst_data", cData,      32'd0);
    check("rst_cs",   32'(cCs),   32'd1);
    check("rst_req",  32'(cReq),  32'd0);
    check("rst_mdat", 32'(cMmcData), 32'hFF);

    // CMD0, R1 after two FF polls
    rxQ = '{8'hFF, 8'hFF, 8'h01};
    e0 = endCnt0;
    startCmd(6'd0, 32'h0, 2'd0);
    check("cmd0_busy", 32'(cBusy), 32'd1);
    waitEnd("cmd0", 200);
    check("cmd0_cs_end", 32'(cCs), 32'd1);
    check("cmd0_r1",  32'(cR1),  32'h01);
    check("cmd0_err", 32'(cErr), 32'd0);
    repeat (3) tick();
    check("cmd0_b0", 32'(txAt(0)), 32'h40);
    check("cmd0_b1", 32'(txAt(1)), 32'h00);
    check("cmd0_b4", 32'(txAt(4)), 32'h00);
    check("cmd0_b5", 32'(txAt(5)), 32'h95);
    check("cmd0_txn", 32'(txLog.size()), 32'd9);
    check("cmd0_endcnt", 32'(endCnt0 - e0), 32'd1);
    check("cmd0_idle", 32'(cBusy), 32'd0);

    // CMD8 R7 with 4-byte payload
    rxQ = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    startCmd(6'd8, 32'h0000_01AA, 2'd2);
    waitEnd("cmd8", 200);
    check("cmd8_r1",   32'(cR1),  32'h01);
    check("cmd8_data", cData,     32'h0000_01AA);
    check("cmd8_err",  32'(cErr), 32'd0);
    repeat (3) tick();
    check("cmd8_b0", 32'(txAt(0)), 32'h48);
    check("cmd8_b3", 32'(txAt(3)), 32'h01);
    check("cmd8_b4", 32'(txAt(4)), 32'hAA);
    check("cmd8_b5", 32'(txAt(5)), 32'h87);
    check("cmd8_txn", 32'(txLog.size()), 32'd11);

    // CMD17 never answered: R1 timeout after exactly 8 polls
    rxQ.delete();
    startCmd(6'd17, 32'h0, 2'd0);
    waitEnd("cmd17", 300);
    check("cmd17_err",    32'(cErr), 32'd1);
    check("cmd17_cs_end", 32'(cCs),  32'd1);
    check("cmd17_r1",     32'(cR1),  32'hFF);
    repeat (3) tick();
    check("cmd17_polls", 32'(txLog.size() - 6), 32'd8);

    // CMD12 R1b: busy released after two busy bytes; short-timeout instance errors
    rxQ = '{8'h00, 8'h00, 8'h00, 8'hFF};
    e1 = endCnt1;
    startCmd(6'd12, 32'h0, 2'd1);
    waitEnd("cmd12", 300);
    check("cmd12_err", 32'(cErr), 32'd0);
    check("cmd12_r1",  32'(cR1),  32'h00);
    repeat (3) tick();
    check("cmd12_b0",   32'(txAt(0)), 32'h4C);
    check("cmd12_txn",  32'(txLog.size()), 32'd10);
    check("cmd12s_err", 32'(bErr), 32'd2);
    check("cmd12s_r1",  32'(bR1),  32'h00);
    check("cmd12s_endcnt", 32'(endCnt1 - e1), 32'd1);

    // SPI master busy held mid-frame with a stray start
    rxQ = '{8'h00};
    e0 = endCnt0;
    startCmd(6'd17, 32'h1234_5678, 2'd0);
    waitTx("hold", 2, 50);
    iMMC_BUSY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        iCMD_START = 1'b1;
        iCMD_INDEX = 6'd0;
        iCMD_RESP_TYPE = 2'd2;
      end else begin
        iCMD_START = 1'b0;
      end
      tick();
      check("hold_req",  32'(cReq),     32'd0);
      check("hold_mdat", 32'(cMmcData), 32'h34);
    end
    iCMD_START = 1'b0;
    check("hold_frozen", 32'(txLog.size()), 32'd2);
    iMMC_BUSY = 1'b0;
    waitEnd("hold", 200);
    check("hold_r1",  32'(cR1),  32'h00);
    check("hold_err", 32'(cErr), 32'd0);
    repeat (3) tick();
    check("hold_b0", 32'(txAt(0)), 32'h51);
    check("hold_b1", 32'(txAt(1)), 32'h12);
    check("hold_b2", 32'(txAt(2)), 32'h34);
    check("hold_b3", 32'(txAt(3)), 32'h56);
    check("hold_b4", 32'(txAt(4)), 32'h78);
    check("hold_b5", 32'(txAt(5)), 32'(crcByte5(40'h51_1234_5678)));
    check("hold_txn", 32'(txLog.size()), 32'd7);
    check("hold_endcnt", 32'(endCnt0 - e0), 32'd1);
    check("hold_idle", 32'(cBusy), 32'd0);

    // Soft reset in the middle of the R7 payload
    rxQ = '{8'h01, 8'hAA, 8'hBB};
    e0 = endCnt0;
    startCmd(6'd8, 32'h0000_01AA, 2'd2);
    waitTx("srst", 8, 100);
    check("srst_busy_pre", 32'(cBusy), 32'd1);
    iRESET_SYNC = 1'b1;
    tick();
    iRESET_SYNC = 1'b0;
    check("srst_busy", 32'(cBusy), 32'd0);
    check("srst_cs",   32'(cCs),   32'd1);
    check("srst_end",  32'(cEnd),  32'd0);
    check("srst_r1",   32'(cR1),   32'hFF);
    check("srst_data", cData,      32'd0);
    repeat (4) tick();
    check("srst_noend", 32'(endCnt0 - e0), 32'd0);

    // CMD58 R3 after soft reset
    rxQ = '{8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
    startCmd(6'd58, 32'h0, 2'd2);
    waitEnd("cmd58", 200);
    check("cmd58_r1",   32'(cR1),  32'h00);
    check("cmd58_data", cData,     32'hC0FF_8000);
    check("cmd58_err",  32'(cErr), 32'd0);
    repeat (3) tick();
    check("cmd58_b0", 32'(txAt(0)), 32'h7A);
    check("cmd58_txn", 32'(txLog.size()), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
